present_dec_control: RTL and testbench
======================================

# present_dec_control

Control FSM for the PRESENT-80 decryption datapath. It is the inverse-direction counterpart of the encryption control block, and it drives the same key register, state register and key-schedule counter.
- Decryption needs round key K32 first, so a key load runs the forward key schedule 31 times.
- Each block decryption then walks the inverse schedule from K32 down to K1.
- After each block, the forward schedule is replayed to restore K32 for the next block.

## Interface
Parameters: none (PRESENT-80 with 31 rounds is fixed).

Ports:
- inClk  in  1  system clock; all state updates on the rising edge
- inRstN  in  1  asynchronous, active-low reset
- inKeyExtWr  in  1  request to load a new external key; sampled level
- inExtDataWr  in  1  request to load and decrypt one ciphertext block; sampled level
- outKeyExtWr  out  1  key register ← external key
- outKeyIntWr  out  1  key register ← forward update(key, outRoundCounter)
- outKeyInvWr  out  1  key register ← inverse update(key, outRoundCounter)
- outStateExtWr  out  1  state register ← external ciphertext
- outStateIntWr  out  1  state register ← datapath result
- outWhiten  out  1  datapath mux select: 1 = state ^ key; 0 = invS(invP(state)) ^ invUpdate(key, outRoundCounter)
- outDataIntWr  out  1  output register ← state (plaintext valid)
- outRoundCounter  out  5  round counter fed to the key schedule
- outBusy  out  1  operation in progress; requests ignored
- outKeyReady  out  1  K32 present in key register; block may be started

## Operation
FSM states: IDLE, LOADK, KFWD, READY, LOADD, WHITEN, ROUND, OUT, RESTORE.

Output decoding:
- All outputs are Moore outputs, decoded from the state register and counter only.
- Every strobe is 0 outside the states listed below.

Per-state behaviour:
- IDLE: outBusy=0, outKeyReady=0, counter=0.
  - inKeyExtWr=1 → LOADK.
  - inExtDataWr is ignored.
- LOADK: outKeyExtWr=1, outBusy=1, counter ← 1. Next state KFWD.
- KFWD: outKeyIntWr=1, outBusy=1, outRoundCounter=counter (1..31), counter increments.
  - After counter=31 → READY, counter ← 0.
- READY: outKeyReady=1, outBusy=0.
  - inKeyExtWr=1 → LOADK. Key has priority when both requests are high.
  - Otherwise inExtDataWr=1 → LOADD.
- LOADD: outStateExtWr=1, outBusy=1. Next state WHITEN.
- WHITEN: outStateIntWr=1, outWhiten=1, outRoundCounter=0, counter ← 31. Next state ROUND.
- ROUND: outStateIntWr=1, outKeyInvWr=1, outWhiten=0, outRoundCounter=counter (31 down to 1), counter decrements.
  - After counter=1 → OUT. The key register then holds K1.
- OUT: outDataIntWr=1, counter ← 1. Next state RESTORE.
- RESTORE: identical strobes to KFWD (outKeyIntWr=1, counter 1..31).
  - After counter=31 → READY, counter ← 0.

Counter:
- Counter is 5 bits and never wraps: 0 is never used as a round value and 32 is never reached.
- outRoundCounter=0 in IDLE, LOADK, READY, LOADD, WHITEN and OUT.

Request handling:
- Requests seen while outBusy=1 are dropped, not queued.
- A request held high after completion is re-sampled in READY and starts a new operation.

## Timing
- Reset (asynchronous, inRstN=0): state=IDLE, counter=0, every output 0 including outKeyReady and outBusy. Reset mid-operation aborts immediately; a new key load is required after release.
- Request latency: a request sampled at edge N puts its first strobe in the cycle following edge N.
- Key load: outBusy=1 for 32 cycles (1 LOADK + 31 KFWD). outKeyReady=1 from cycle 33.
- Block decrypt: outBusy=1 for 65 cycles (LOADD 1, WHITEN 1, ROUND 31, OUT 1, RESTORE 31).
  - outDataIntWr is high in busy cycle 34, exactly one cycle wide.
  - READY is re-entered in cycle 66.
- Back-to-back blocks: inExtDataWr held high gives one block every 66 cycles (65 busy + 1 READY).
- Strobe exclusivity: at most one key-register strobe (outKeyExtWr, outKeyIntWr, outKeyInvWr) is high in any cycle. The same holds for the state-register strobes (outStateExtWr, outStateIntWr).

## Test plan
- Reset with both requests high, then release: all outputs 0 until the first edge after release; the first sampled inKeyExtWr gives outKeyExtWr=1 for exactly one cycle.
- Key load: outKeyIntWr high for 31 consecutive cycles with outRoundCounter=1,2,…,31; then outKeyReady=1, outBusy=0.
- Decrypt with key 0x00000000000000000000 and ciphertext 0x5579C1387B228445 through a datapath model: outDataIntWr pulses in busy cycle 34 with plaintext 0x0000000000000000. outRoundCounter in ROUND runs 31 down to 1.
- Key restore check: decrypt a second block immediately with ciphertext 0x5579C1387B228445; same plaintext is produced, confirming K32 was restored.
- inExtDataWr in IDLE, and both requests during a busy phase: no strobes from IDLE; busy operation unaffected. Both requests high in READY → LOADK taken.
- Assert inRstN=0 at ROUND counter=15: outputs 0 the same cycle (asynchronous). After release, inExtDataWr alone is ignored and outKeyReady=0.

Source files
------------

// File: rtl/present_dec_control.sv
// Control FSM for the PRESENT-80 decryption datapath: loads the key and rolls it
// forward to K32, decrypts by walking the schedule back to K1, then replays it to K32.
module present_dec_control (
    input  logic       inClk,
    input  logic       inRstN,
    input  logic       inKeyExtWr,
    input  logic       inExtDataWr,
    output logic       outKeyExtWr,
    output logic       outKeyIntWr,
    output logic       outKeyInvWr,
    output logic       outStateExtWr,
    output logic       outStateIntWr,
    output logic       outWhiten,
    output logic       outDataIntWr,
    output logic [4:0] outRoundCounter,
    output logic       outBusy,
    output logic       outKeyReady
);

    localparam logic [4:0] LP_FIRST_ROUND = 5'd1;
    localparam logic [4:0] LP_LAST_ROUND  = 5'd31;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOADK,
        S_KFWD,
        S_READY,
        S_LOADD,
        S_WHITEN,
        S_ROUND,
        S_OUT,
        S_RESTORE
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_next;

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter. The counter is only meaningful in KFWD, ROUND and
    // RESTORE; it is parked at 0 elsewhere so it never wraps or reaches 32.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (inKeyExtWr) begin
                    w_state_next = S_LOADK;
                end
            end
            S_LOADK: begin
                w_cnt_next   = LP_FIRST_ROUND;
                w_state_next = S_KFWD;
            end
            S_KFWD, S_RESTORE: begin
                if (r_cnt == LP_LAST_ROUND) begin
                    w_cnt_next   = '0;
                    w_state_next = S_READY;
                end else begin
                    w_cnt_next = r_cnt + 5'd1;
                end
            end
            S_READY: begin
                w_cnt_next = '0;
                // A new key takes priority over a block request.
                if (inKeyExtWr) begin
                    w_state_next = S_LOADK;
                end else if (inExtDataWr) begin
                    w_state_next = S_LOADD;
                end
            end
            S_LOADD: begin
                w_cnt_next   = '0;
                w_state_next = S_WHITEN;
            end
            S_WHITEN: begin
                w_cnt_next   = LP_LAST_ROUND;
                w_state_next = S_ROUND;
            end
            S_ROUND: begin
                if (r_cnt == LP_FIRST_ROUND) begin
                    w_cnt_next   = '0;
                    w_state_next = S_OUT;
                end else begin
                    w_cnt_next = r_cnt - 5'd1;
                end
            end
            S_OUT: begin
                w_cnt_next   = LP_FIRST_ROUND;
                w_state_next = S_RESTORE;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Moore output decode from state and counter only.
    always_comb begin
        outKeyExtWr     = 1'b0;
        outKeyIntWr     = 1'b0;
        outKeyInvWr     = 1'b0;
        outStateExtWr   = 1'b0;
        outStateIntWr   = 1'b0;
        outWhiten       = 1'b0;
        outDataIntWr    = 1'b0;
        outRoundCounter = '0;
        outBusy         = 1'b0;
        outKeyReady     = 1'b0;
        case (r_state)
            S_LOADK: begin
                outKeyExtWr = 1'b1;
                outBusy     = 1'b1;
            end
            S_KFWD, S_RESTORE: begin
                outKeyIntWr     = 1'b1;
                outRoundCounter = r_cnt;
                outBusy         = 1'b1;
            end
            S_READY: begin
                outKeyReady = 1'b1;
            end
            S_LOADD: begin
                outStateExtWr = 1'b1;
                outBusy       = 1'b1;
            end
            S_WHITEN: begin
                outStateIntWr = 1'b1;
                outWhiten     = 1'b1;
                outBusy       = 1'b1;
            end
            S_ROUND: begin
                outStateIntWr   = 1'b1;
                outKeyInvWr     = 1'b1;
                outRoundCounter = r_cnt;
                outBusy         = 1'b1;
            end
            S_OUT: begin
                outDataIntWr = 1'b1;
                outBusy      = 1'b1;
            end
            default: begin
                outBusy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_present_dec_control.sv
// Directed bench for present_dec_control with a PRESENT-80 datapath model
// driven by the controller strobes.
module tb_present_dec_control;

    logic       inClk = 1'b0;
    logic       inRstN;
    logic       inKeyExtWr;
    logic       inExtDataWr;
    logic       outKeyExtWr;
    logic       outKeyIntWr;
    logic       outKeyInvWr;
    logic       outStateExtWr;
    logic       outStateIntWr;
    logic       outWhiten;
    logic       outDataIntWr;
    logic [4:0] outRoundCounter;
    logic       outBusy;
    logic       outKeyReady;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [79:0] EXT_KEY = 80'h0;
    localparam logic [63:0] CT      = 64'h5579C1387B228445;
    localparam logic [63:0] PT      = 64'h0;

    always #5 inClk = ~inClk;

    present_dec_control dut (
        .inClk          (inClk),
        .inRstN         (inRstN),
        .inKeyExtWr     (inKeyExtWr),
        .inExtDataWr    (inExtDataWr),
        .outKeyExtWr    (outKeyExtWr),
        .outKeyIntWr    (outKeyIntWr),
        .outKeyInvWr    (outKeyInvWr),
        .outStateExtWr  (outStateExtWr),
        .outStateIntWr  (outStateIntWr),
        .outWhiten      (outWhiten),
        .outDataIntWr   (outDataIntWr),
        .outRoundCounter(outRoundCounter),
        .outBusy        (outBusy),
        .outKeyReady    (outKeyReady)
    );

    logic [13:0] w_got;
    assign w_got = {outKeyExtWr, outKeyIntWr, outKeyInvWr, outStateExtWr, outStateIntWr,
                    outWhiten, outDataIntWr, outBusy, outKeyReady, outRoundCounter};

    // ---------------- PRESENT-80 datapath model ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[x*4 +: 4];
    endfunction

    function automatic logic [3:0] isb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hA970364BD21C8FE5;
        return t[x*4 +: 4];
    endfunction

    function automatic logic [63:0] isb64(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = isb(s[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] invp(input logic [63:0] s);
        logic [63:0] r;
        int p;
        for (int i = 0; i < 64; i++) begin
            p = (i == 63) ? 63 : ((i * 16) % 63);
            r[i] = s[p];
        end
        return r;
    endfunction

    function automatic logic [79:0] kfwd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sb(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [79:0] kinv(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t = k;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = isb(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    logic [79:0] m_key;
    logic [63:0] m_state;
    logic [63:0] m_pt;
    int          m_ptcnt = 0;
    logic [79:0] w_nk;
    assign w_nk = kinv(m_key, outRoundCounter);

    always @(posedge inClk) begin
        if (outKeyExtWr)      m_key <= EXT_KEY;
        else if (outKeyIntWr) m_key <= kfwd(m_key, outRoundCounter);
        else if (outKeyInvWr) m_key <= w_nk;
        if (outStateExtWr)      m_state <= CT;
        else if (outStateIntWr) m_state <= outWhiten ? (m_state ^ m_key[79:16])
                                                     : (isb64(invp(m_state)) ^ w_nk[79:16]);
        if (outDataIntWr) begin
            m_pt    <= m_state;
            m_ptcnt <= m_ptcnt + 1;
        end
    end

    // ---------------- expected-output helpers ----------------
    function automatic logic [13:0] mk(input logic kx, input logic ki, input logic kv,
                                       input logic sx, input logic si, input logic wh,
                                       input logic dt, input logic bz, input logic rd,
                                       input logic [4:0] rc);
        return {kx, ki, kv, sx, si, wh, dt, bz, rd, rc};
    endfunction

    function automatic logic [13:0] e_loadk();  return mk(1,0,0,0,0,0,0,1,0,5'd0); endfunction
    function automatic logic [13:0] e_kfwd(input logic [4:0] rc); return mk(0,1,0,0,0,0,0,1,0,rc); endfunction
    function automatic logic [13:0] e_ready();  return mk(0,0,0,0,0,0,0,0,1,5'd0); endfunction
    function automatic logic [13:0] e_loadd();  return mk(0,0,0,1,0,0,0,1,0,5'd0); endfunction
    function automatic logic [13:0] e_whiten(); return mk(0,0,0,0,1,1,0,1,0,5'd0); endfunction
    function automatic logic [13:0] e_round(input logic [4:0] rc); return mk(0,0,1,0,1,0,0,1,0,rc); endfunction
    function automatic logic [13:0] e_out();    return mk(0,0,0,0,0,0,1,1,0,5'd0); endfunction

    // Expected outputs in cycle c (1-based) of a block decrypt started from READY.
    function automatic logic [13:0] e_blk(input int c);
        if (c == 1)       return e_loadd();
        else if (c == 2)  return e_whiten();
        else if (c <= 33) return e_round(5'(34 - c));
        else if (c == 34) return e_out();
        else if (c <= 65) return e_kfwd(5'(c - 34));
        else              return e_ready();
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        n_checks++;
        if (w_got !== exp) begin
            n_errors++;
            $display("FAIL %s: got outputs %h, expected %h", name, w_got, exp);
        end
    endtask

    task automatic check_pt(input string name, input int exp_cnt);
        n_checks++;
        if (m_ptcnt != exp_cnt || m_pt !== PT) begin
            n_errors++;
            $display("FAIL %s: got %0d blocks pt=%h, expected %0d blocks pt=%h",
                     name, m_ptcnt, m_pt, exp_cnt, PT);
        end
    endtask

    task automatic step(input logic k, input logic d);
        inKeyExtWr  = k;
        inExtDataWr = d;
        @(posedge inClk);
        #1;
    endtask

    typedef struct {
        logic        kwr;
        logic        dwr;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        inRstN      = 1'b0;
        inKeyExtWr  = 1'b1;
        inExtDataWr = 1'b1;

        // Key load start (busy-phase requests must be dropped).
        vecs[0] = '{1'b1, 1'b1, e_loadk()};
        vecs[1] = '{1'b1, 1'b1, e_kfwd(5'd1)};
        vecs[2] = '{1'b0, 1'b1, e_kfwd(5'd2)};
        vecs[3] = '{1'b1, 1'b0, e_kfwd(5'd3)};
        // Block decrypt start from READY.
        vecs[4] = '{1'b0, 1'b1, e_loadd()};
        vecs[5] = '{1'b0, 1'b0, e_whiten()};
        vecs[6] = '{1'b0, 1'b0, e_round(5'd31)};
        vecs[7] = '{1'b0, 1'b0, e_round(5'd30)};

        repeat (2) @(posedge inClk);
        #1;
        check("reset_hold", 14'h0);
        #3 inRstN = 1'b1;
        #1;
        check("release_before_edge", 14'h0);

        for (int i = 0; i < 4; i++) begin
            step(vecs[i].kwr, vecs[i].dwr);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        for (int rc = 4; rc <= 31; rc++) begin
            step(1'b0, 1'b0);
            check($sformatf("keyload_rc%0d", rc), e_kfwd(5'(rc)));
        end
        step(1'b0, 1'b0);
        check("keyload_ready", e_ready());
        step(1'b0, 1'b0);
        check("ready_idle_hold", e_ready());

        // Block 1.
        for (int i = 4; i < 8; i++) begin
            step(vecs[i].kwr, vecs[i].dwr);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        for (int c = 5; c <= 66; c++) begin
            step(1'b0, 1'b0);
            check($sformatf("blk1_c%0d", c), e_blk(c));
        end
        check_pt("blk1_plaintext", 1);

        // Block 2: request held high, back-to-back, proves K32 restored.
        for (int c = 1; c <= 66; c++) begin
            step(1'b0, 1'b1);
            check($sformatf("blk2_c%0d", c), e_blk(c));
        end
        check_pt("blk2_plaintext", 2);

        // Block 3: both requests held high through the busy phase.
        step(1'b0, 1'b1);
        check("blk3_c1", e_blk(1));
        for (int c = 2; c <= 66; c++) begin
            step(1'b1, 1'b1);
            check($sformatf("blk3_c%0d", c), e_blk(c));
        end
        check_pt("blk3_plaintext", 3);

        // Both requests in READY: key wins.
        step(1'b1, 1'b1);
        check("ready_both_loadk", e_loadk());
        for (int rc = 1; rc <= 31; rc++) begin
            step(1'b0, 1'b0);
            check($sformatf("reload_rc%0d", rc), e_kfwd(5'(rc)));
        end
        step(1'b0, 1'b0);
        check("reload_ready", e_ready());

        // Block 4 aborted by asynchronous reset at ROUND counter 15.
        for (int c = 1; c <= 19; c++) begin
            step(1'b0, (c == 1));
            check($sformatf("blk4_c%0d", c), e_blk(c));
        end
        #2 inRstN = 1'b0;
        #1;
        check("async_reset_same_cycle", 14'h0);
        @(posedge inClk);
        #1;
        check("async_reset_held", 14'h0);
        #3 inRstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("idle_data_ignored%0d", i), 14'h0);
        end
        check_pt("no_output_after_abort", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
